// File: rtl/predicate_writeback_tracker.sv
// Shadow scoreboard for the three stages after the trigger stage: tracks in-flight
// destinations, flags predicate hazards and commits predicate results at stage 3.
package predicate_writeback_tracker_pkg;
  localparam int unsigned TIA_DT_WIDTH = 2;
  localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_NULL      = 2'd0;
  localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_REGISTER  = 2'd1;
  localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_OUTPUT    = 2'd2;
  localparam logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_PREDICATE = 2'd3;
endpackage

module predicate_writeback_tracker
  import predicate_writeback_tracker_pkg::*;
#(
  parameter int unsigned NUM_PREDICATES = 8,
  parameter int unsigned PI_WIDTH = $clog2(NUM_PREDICATES),
  parameter logic [NUM_PREDICATES-1:0] INITIAL_PREDICATES = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [TIA_DT_WIDTH-1:0]   issue_dt,
  input  logic [PI_WIDTH-1:0]       issue_pi,
  input  logic                      pipeline_stall,
  input  logic                      flush,
  input  logic                      retire_value,
  output logic [NUM_PREDICATES-1:0] predicates,
  output logic [TIA_DT_WIDTH-1:0]   first_downstream_dt,
  output logic [TIA_DT_WIDTH-1:0]   second_downstream_dt,
  output logic [TIA_DT_WIDTH-1:0]   third_downstream_dt,
  output logic                      hazard,
  output logic [1:0]                in_flight_count,
  output logic                      issue_error
);

  logic [2:0]              slot_valid;
  logic [TIA_DT_WIDTH-1:0] slot_dt [3];
  logic [PI_WIDTH-1:0]     slot_pi [3];
  logic [2:0]              slot_is_pred;
  logic                    retire;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      slot_is_pred[i] = slot_valid[i] && (slot_dt[i] == TIA_DESTINATION_TYPE_PREDICATE);
    end
  end

  assign hazard          = |slot_is_pred;
  assign in_flight_count = 2'(slot_is_pred[0]) + 2'(slot_is_pred[1]) + 2'(slot_is_pred[2]);
  assign retire          = slot_is_pred[2] && !pipeline_stall;

  assign first_downstream_dt  = slot_valid[0] ? slot_dt[0] : TIA_DESTINATION_TYPE_NULL;
  assign second_downstream_dt = slot_valid[1] ? slot_dt[1] : TIA_DESTINATION_TYPE_NULL;
  assign third_downstream_dt  = slot_valid[2] ? slot_dt[2] : TIA_DESTINATION_TYPE_NULL;

  // Commit happens before squash, so a flush edge still retires slot3.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid  <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_dt[i] <= TIA_DESTINATION_TYPE_NULL;
        slot_pi[i] <= '0;
      end
      predicates  <= INITIAL_PREDICATES;
      issue_error <= 1'b0;
    end else begin
      if (retire) begin
        for (int i = 0; i < NUM_PREDICATES; i++) begin
          if (slot_pi[2] == PI_WIDTH'(i)) predicates[i] <= retire_value;
        end
      end
      if (issue_valid && !flush && (pipeline_stall || hazard)) issue_error <= 1'b1;
      if (flush) begin
        slot_valid <= '0;
      end else if (!pipeline_stall) begin
        slot_valid <= {slot_valid[1], slot_valid[0], issue_valid && !hazard};
        slot_dt[2] <= slot_dt[1];
        slot_dt[1] <= slot_dt[0];
        slot_dt[0] <= issue_dt;
        slot_pi[2] <= slot_pi[1];
        slot_pi[1] <= slot_pi[0];
        slot_pi[0] <= issue_pi;
      end
    end
  end

endmodule

// File: tb/tb_predicate_writeback_tracker.sv
// Directed table-driven bench for predicate_writeback_tracker plus a reset-mid-flight sequence.
module tb_predicate_writeback_tracker;
  import predicate_writeback_tracker_pkg::*;

  localparam logic [7:0] INIT = 8'h40;
  localparam logic [1:0] N = TIA_DESTINATION_TYPE_NULL;
  localparam logic [1:0] R = TIA_DESTINATION_TYPE_REGISTER;
  localparam logic [1:0] O = TIA_DESTINATION_TYPE_OUTPUT;
  localparam logic [1:0] P = TIA_DESTINATION_TYPE_PREDICATE;

  logic       clock = 1'b0;
  logic       reset, issue_valid, pipeline_stall, flush, retire_value;
  logic [1:0] issue_dt;
  logic [2:0] issue_pi;
  logic [7:0] predicates;
  logic [1:0] dt1, dt2, dt3, in_flight_count;
  logic       hazard, issue_error;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  predicate_writeback_tracker #(.NUM_PREDICATES(8), .INITIAL_PREDICATES(INIT)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_dt(issue_dt),
    .issue_pi(issue_pi), .pipeline_stall(pipeline_stall), .flush(flush),
    .retire_value(retire_value), .predicates(predicates),
    .first_downstream_dt(dt1), .second_downstream_dt(dt2), .third_downstream_dt(dt3),
    .hazard(hazard), .in_flight_count(in_flight_count), .issue_error(issue_error)
  );

  typedef struct {
    logic       iv;
    logic [1:0] idt;
    logic [2:0] ipi;
    logic       st, fl, rv;
    logic [1:0] e1, e2, e3;
    logic       ehaz;
    logic [1:0] ecnt;
    logic [7:0] epred;
    logic       eerr;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic iv, logic [1:0] idt, logic [2:0] ipi, logic st, logic fl,
                              logic rv, logic [1:0] e1, logic [1:0] e2, logic [1:0] e3,
                              logic ehaz, logic [1:0] ecnt, logic [7:0] epred, logic eerr);
    vec_t v;
    v.iv = iv; v.idt = idt; v.ipi = ipi; v.st = st; v.fl = fl; v.rv = rv;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ehaz = ehaz; v.ecnt = ecnt; v.epred = epred; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(string name, logic [1:0] e1, logic [1:0] e2, logic [1:0] e3,
                       logic ehaz, logic [1:0] ecnt, logic [7:0] epred, logic eerr);
    total++;
    if (dt1 === e1 && dt2 === e2 && dt3 === e3 && hazard === ehaz &&
        in_flight_count === ecnt && predicates === epred && issue_error === eerr) begin
      passed++;
    end else begin
      $display("FAIL %s: got dt=%0d/%0d/%0d haz=%0b cnt=%0d pred=%02h err=%0b, want dt=%0d/%0d/%0d haz=%0b cnt=%0d pred=%02h err=%0b",
               name, dt1, dt2, dt3, hazard, in_flight_count, predicates, issue_error,
               e1, e2, e3, ehaz, ecnt, epred, eerr);
    end
  endtask

  task automatic drive(logic iv, logic [1:0] idt, logic [2:0] ipi, logic st, logic fl, logic rv);
    @(negedge clock);
    issue_valid = iv; issue_dt = idt; issue_pi = ipi;
    pipeline_stall = st; flush = fl; retire_value = rv;
  endtask

  initial begin
    // Basic retire
    vecs[0]  = mk(1, P, 3, 0, 0, 0,  P, N, N, 1, 1, 8'h40, 0);
    vecs[1]  = mk(0, N, 0, 0, 0, 0,  N, P, N, 1, 1, 8'h40, 0);
    vecs[2]  = mk(0, N, 0, 0, 0, 0,  N, N, P, 1, 1, 8'h40, 0);
    vecs[3]  = mk(0, N, 0, 0, 0, 1,  N, N, N, 0, 0, 8'h48, 0);
    // Mixed stream, no predicate writes
    vecs[4]  = mk(1, R, 7, 0, 0, 0,  R, N, N, 0, 0, 8'h48, 0);
    vecs[5]  = mk(1, O, 6, 0, 0, 0,  O, R, N, 0, 0, 8'h48, 0);
    vecs[6]  = mk(1, R, 5, 0, 0, 0,  R, O, R, 0, 0, 8'h48, 0);
    vecs[7]  = mk(0, N, 0, 0, 0, 1,  N, R, O, 0, 0, 8'h48, 0);
    vecs[8]  = mk(0, N, 0, 0, 0, 1,  N, N, R, 0, 0, 8'h48, 0);
    vecs[9]  = mk(0, N, 0, 0, 0, 1,  N, N, N, 0, 0, 8'h48, 0);
    // Stall two cycles with write in slot2
    vecs[10] = mk(1, P, 1, 0, 0, 0,  P, N, N, 1, 1, 8'h48, 0);
    vecs[11] = mk(0, N, 0, 0, 0, 0,  N, P, N, 1, 1, 8'h48, 0);
    vecs[12] = mk(0, N, 0, 1, 0, 1,  N, P, N, 1, 1, 8'h48, 0);
    vecs[13] = mk(0, N, 0, 1, 0, 1,  N, P, N, 1, 1, 8'h48, 0);
    vecs[14] = mk(0, N, 0, 0, 0, 0,  N, N, P, 1, 1, 8'h48, 0);
    vecs[15] = mk(0, N, 0, 0, 0, 1,  N, N, N, 0, 0, 8'h4A, 0);
    // Flush with slot3 retiring and a same-cycle issue that is dropped silently
    vecs[16] = mk(1, P, 0, 0, 0, 0,  P, N, N, 1, 1, 8'h4A, 0);
    vecs[17] = mk(0, N, 0, 0, 0, 0,  N, P, N, 1, 1, 8'h4A, 0);
    vecs[18] = mk(0, N, 0, 0, 0, 0,  N, N, P, 1, 1, 8'h4A, 0);
    vecs[19] = mk(1, P, 2, 0, 1, 1,  N, N, N, 0, 0, 8'h4B, 0);
    // Flush while stalled: cleared, no retire
    vecs[20] = mk(1, P, 2, 0, 0, 0,  P, N, N, 1, 1, 8'h4B, 0);
    vecs[21] = mk(0, N, 0, 1, 1, 1,  N, N, N, 0, 0, 8'h4B, 0);
    // Illegal issues: under hazard, then under stall
    vecs[22] = mk(1, P, 4, 0, 0, 0,  P, N, N, 1, 1, 8'h4B, 0);
    vecs[23] = mk(1, R, 0, 0, 0, 0,  N, P, N, 1, 1, 8'h4B, 1);
    vecs[24] = mk(0, N, 0, 0, 0, 0,  N, N, P, 1, 1, 8'h4B, 1);
    vecs[25] = mk(0, N, 0, 0, 0, 1,  N, N, N, 0, 0, 8'h5B, 1);
    vecs[26] = mk(1, R, 0, 1, 0, 0,  N, N, N, 0, 0, 8'h5B, 1);
    vecs[27] = mk(0, N, 0, 0, 0, 0,  N, N, N, 0, 0, 8'h5B, 1);

    reset = 1'b1; issue_valid = 0; issue_dt = N; issue_pi = 0;
    pipeline_stall = 0; flush = 0; retire_value = 0;
    repeat (2) @(posedge clock);
    #1 check("reset_state", N, N, N, 0, 0, INIT, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].iv, vecs[i].idt, vecs[i].ipi, vecs[i].st, vecs[i].fl, vecs[i].rv);
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3,
               vecs[i].ehaz, vecs[i].ecnt, vecs[i].epred, vecs[i].eerr);
    end

    // Reset mid-flight: write in slot2 is discarded, error and predicates return to reset
    drive(1, P, 5, 0, 0, 1);
    @(posedge clock);
    drive(0, N, 0, 0, 0, 1);
    @(posedge clock);
    #1 check("pre_reset_slot2", N, P, N, 1, 1, 8'h5B, 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check("reset_midflight", N, N, N, 0, 0, INIT, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("post_reset_no_retire", N, N, N, 0, 0, INIT, 0);

    // Back-to-back legal predicate write right after the previous one retires
    drive(1, P, 7, 0, 0, 0);
    @(posedge clock);
    drive(0, N, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    drive(0, N, 0, 0, 0, 1);
    @(posedge clock);
    #1 check("retire_pi7", N, N, N, 0, 0, 8'hC0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/predicate_writeback_tracker.md
# predicate_writeback_tracker

Shadow scoreboard for the three pipeline stages downstream of the trigger stage. It records the destination type and index of every issued instruction and raises `hazard` while any predicate write is in flight. It commits predicate results into the architectural predicate register when the write leaves the third stage. It produces the per-stage destination types that the control hazard detection logic consumes, and closes the loop by retiring the writes that logic waits on.

## Interface

Parameters:
- `NUM_PREDICATES`, default 8: number of architectural predicate bits (≥2).
- `PI_WIDTH`, default `$clog2(NUM_PREDICATES)`: predicate index width.
- `INITIAL_PREDICATES`, default `'0`: reset value of the predicate register.

Ports:
- `clock`  in  1  — sole clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `issue_valid`  in  1  — instruction enters stage 1 this cycle.
- `issue_dt`  in  `TIA_DT_WIDTH`  — destination type of issuing instruction.
- `issue_pi`  in  `PI_WIDTH`  — destination predicate index; ignored unless `issue_dt` is `TIA_DESTINATION_TYPE_PREDICATE`.
- `pipeline_stall`  in  1  — when high, no stage advances.
- `flush`  in  1  — squash all in-flight instructions.
- `retire_value`  in  1  — predicate result from the stage-3 datapath this cycle.
- `predicates`  out  `NUM_PREDICATES`  — architectural predicate state.
- `first_downstream_dt`, `second_downstream_dt`, `third_downstream_dt`  out  `TIA_DT_WIDTH`  — destination type held in stages 1/2/3; `TIA_DESTINATION_TYPE_NULL` when the slot is empty.
- `hazard`  out  1  — any occupied slot has a predicate destination.
- `in_flight_count`  out  2  — number of occupied slots with a predicate destination (0–3).
- `issue_error`  out  1  — sticky; an issue was attempted while stalled or while `hazard` was high.

## Operation

- **State:** three slots, each holding {valid, dt, pi}, plus the predicate register and the sticky error bit.
- **Reset:**
  - all slots invalid;
  - `predicates` = `INITIAL_PREDICATES`;
  - `issue_error` = 0;
  - all dt outputs = NULL;
  - `hazard` = 0;
  - `in_flight_count` = 0.
- **Priority:** reset > flush > stall > advance.
- **Advance** (`pipeline_stall` = 0, `flush` = 0):
  - slot3 ← slot2;
  - slot2 ← slot1;
  - slot1 ← {`issue_valid` accepted, `issue_dt`, `issue_pi`}.
- **Retire:** on any edge where slot3 is valid, its dt = PREDICATE, and `pipeline_stall` = 0:
  - `predicates[slot3.pi]` ← `retire_value`;
  - retire happens even if `flush` is high that cycle (commit precedes squash).
- **Flush** (no stall):
  - slot3 retires per the rule above;
  - then all three slots are cleared;
  - any issue in the same cycle is dropped; this is not an error.
- **Flush while stalled:** all slots cleared, no retire.
- **Stall:** all slots and `predicates` hold. `issue_valid` during a stall is dropped and sets `issue_error`.
- **Issue while `hazard` = 1:** dropped (slot1 becomes invalid) and sets `issue_error`. The upstream trigger stage must hold issue while `hazard` is high.
- **`issue_error`:** cleared only by reset.
- **Combinational outputs:** `hazard` and `in_flight_count` are purely combinational from slot registers, with no input-to-output path. dt outputs come directly from slot registers, forced to NULL when a slot is invalid.
- **Out-of-range index:** a `pi` ≥ `NUM_PREDICATES` at retire leaves `predicates` unchanged.

## Timing

- Issue accepted in cycle N (no stall):
  - occupies slot1 in N+1, slot2 in N+2, slot3 in N+3;
  - retires at the edge ending N+3;
  - new predicate value visible in N+4.
- For a predicate-destination issue, `hazard` is high in N+1 through N+3 and low in N+4, provided nothing else is in flight.
- Each stall cycle extends occupancy by one cycle per stalled cycle. `retire_value` is sampled only on the retiring edge.
- Latency from issue to visible predicate is 4 cycles plus the number of stall cycles.
- After a flush at the edge ending cycle M, all dt outputs are NULL and `hazard` = 0 in M+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge; in-flight writes are discarded without retiring.

## Test plan

- **Basic retire:** reset, then issue PREDICATE with `pi` = 3 in cycle 1; drive `retire_value` = 1 in cycle 4 → `hazard` = 1 in cycles 2–4; `third_downstream_dt` = PREDICATE in cycle 4; `predicates` = 8'b0000_1000 in cycle 5; `hazard` = 0 in cycle 5.
- **Mixed stream:** issue REGISTER, OUTPUT, REGISTER back-to-back → dt outputs shift one stage per cycle; `hazard` stays 0; `predicates` unchanged.
- **Stall:** issue PREDICATE with `pi` = 1, then stall 2 cycles while the write is in slot2 → slot contents hold; `hazard` high for 5 cycles; bit 1 updates 2 cycles later than in the basic retire case; no write occurs during the stall.
- **Flush:** PREDICATE writes in slot3 (`pi` = 0, `retire_value` = 1) and slot1 (`pi` = 2); assert flush with no stall → bit 0 = 1, bit 2 unchanged; next cycle all dt outputs NULL and `in_flight_count` = 0.
- **Illegal issue:** issue with `hazard` high, then issue with `pipeline_stall` high → both dropped; `issue_error` = 1 and stays 1 until reset.
- **Reset mid-flight:** PREDICATE in slot2, then assert reset → next cycle slots empty; `predicates` = `INITIAL_PREDICATES`; no retire occurs.
